// File: rtl/datapath_cw_sequencer.sv
// Micro-op queue and issue FSM driving the LEGv8 datapath ControlWord/constant, one entry per cycle.
// Optional feature: define SEQ_SKIP_EN for status-conditional skip of the following entry.
module datapath_cw_sequencer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [24:0] NOP_CW      = 25'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_valid,
  output logic        push_ready,
  input  logic [24:0] push_cw,
  input  logic [63:0] push_const,
  input  logic [1:0]  push_op,
  input  logic        go,
  input  logic [3:0]  status,
  output logic [24:0] ControlWord,
  output logic [63:0] constant,
  output logic        busy,
  output logic        done,
  output logic [15:0] issue_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [1:0] OpNormal = 2'b00;
  localparam logic [1:0] OpHold   = 2'b01;
  localparam logic [1:0] OpSkip   = 2'b10;
  localparam logic [1:0] OpHalt   = 2'b11;

  typedef enum logic [1:0] {StIdle, StRun, StHold, StSkip} state_e;

  logic [24:0] mem_cw    [DEPTH];
  logic [63:0] mem_const [DEPTH];
  logic [1:0]  mem_op    [DEPTH];

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full, empty, push_en, pop;

  state_e      state_q, state_d;
  logic [24:0] cw_q, cw_d;
  logic [63:0] const_q, const_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic        issued_q, issued_d;
  logic [3:0]  status_q;
  logic        take;

  logic [24:0] head_cw;
  logic [63:0] head_const;
  logic [1:0]  head_op;

  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ready = !full;
  assign push_en    = push_valid && !full;

  assign head_cw    = mem_cw[rd_ptr_q[AW-1:0]];
  assign head_const = mem_const[rd_ptr_q[AW-1:0]];
  assign head_op    = mem_op[rd_ptr_q[AW-1:0]];

`ifdef SEQ_SKIP_EN
  logic [2:0] skip_sel_q, skip_sel_d;
  logic       skip_cond;
  assign skip_cond = status_q[skip_sel_q[1:0]] ^ skip_sel_q[2];
`else
  logic unused_status;
  assign unused_status = ^status_q;
`endif

  always_comb begin
    state_d  = state_q;
    cw_d     = NOP_CW;
    const_d  = const_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    issued_d = 1'b0;
    pop      = 1'b0;
    take     = 1'b0;
`ifdef SEQ_SKIP_EN
    skip_sel_d = skip_sel_q;
`endif
    case (state_q)
      StIdle: begin
        if (go) begin
          if (empty) done_d = 1'b1;
          else       take   = 1'b1;
        end
      end
      StRun: take = 1'b1;
      StHold: begin
        if (hcnt_q == '0) take   = 1'b1;
        else              hcnt_d = hcnt_q - 1'b1;
      end
`ifdef SEQ_SKIP_EN
      StSkip: begin
        // Condition true: the entry after the SKIP is dropped while NOP_CW is driven.
        if (skip_cond) begin
          if (empty) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            pop     = 1'b1;
            state_d = StRun;
          end
        end else begin
          take = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (take) begin
      if (empty) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end else begin
        pop = 1'b1;
        unique case (head_op)
          OpNormal, OpHold: begin
            cw_d     = head_cw;
            const_d  = head_const;
            cnt_d    = cnt_q + 16'd1;
            issued_d = 1'b1;
            state_d  = (head_op == OpHold) ? StHold : StRun;
            hcnt_d   = HW'(HOLD_CYCLES);
          end
          OpSkip: begin
`ifdef SEQ_SKIP_EN
            state_d    = StSkip;
            skip_sel_d = head_const[2:0];
`else
            state_d    = StRun;
`endif
          end
          OpHalt: begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) begin
      mem_cw[wr_ptr_q[AW-1:0]]    <= push_cw;
      mem_const[wr_ptr_q[AW-1:0]] <= push_const;
      mem_op[wr_ptr_q[AW-1:0]]    <= push_op;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= StIdle;
      cw_q     <= NOP_CW;
      const_q  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      issued_q <= 1'b0;
      status_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      state_q  <= state_d;
      cw_q     <= cw_d;
      const_q  <= const_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      issued_q <= issued_d;
      // Capture the status produced while an issued cw was on the datapath.
      if (issued_q) status_q <= status;
    end
  end

`ifdef SEQ_SKIP_EN
  always_ff @(posedge clock) begin
    if (reset) skip_sel_q <= '0;
    else       skip_sel_q <= skip_sel_d;
  end
`endif

  assign ControlWord = cw_q;
  assign constant    = const_q;
  assign done        = done_q;
  assign issue_count = cnt_q;
  assign busy        = (state_q == StRun) || (state_q == StHold) || (state_q == StSkip);

endmodule

// File: tb/tb_datapath_cw_sequencer.sv
// Directed self-checking bench for datapath_cw_sequencer (DEPTH=16, HOLD_CYCLES=2, NOP_CW=0).
// Expectations for the SKIP vector depend on whether SEQ_SKIP_EN is defined.
module tb_datapath_cw_sequencer;

  localparam int unsigned DEPTH = 16;

  localparam logic [24:0] CwA = 25'h0AAAA1;
  localparam logic [24:0] CwB = 25'h0BBBB2;
  localparam logic [24:0] CwC = 25'h0CCCC3;

  logic        clock = 1'b0;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [24:0] push_cw;
  logic [63:0] push_const;
  logic [1:0]  push_op;
  logic        go;
  logic [3:0]  status;
  logic [24:0] ControlWord;
  logic [63:0] constant;
  logic        busy;
  logic        done;
  logic [15:0] issue_count;

  int n_total = 0;
  int n_pass  = 0;

  datapath_cw_sequencer #(
    .DEPTH(DEPTH),
    .HOLD_CYCLES(2),
    .NOP_CW(25'd0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .push_valid(push_valid),
    .push_ready(push_ready),
    .push_cw(push_cw),
    .push_const(push_const),
    .push_op(push_op),
    .go(go),
    .status(status),
    .ControlWord(ControlWord),
    .constant(constant),
    .busy(busy),
    .done(done),
    .issue_count(issue_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [24:0] cw, input logic [63:0] c, input logic [1:0] op);
    push_valid = 1'b1;
    push_cw    = cw;
    push_const = c;
    push_op    = op;
    tick();
    push_valid = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  initial begin
    int issued;
    logic [24:0] last_cw;
    reset = 1'b0; push_valid = 1'b0; push_cw = '0; push_const = '0; push_op = 2'b00;
    go = 1'b0; status = 4'h0;
    do_reset();
    check("rst_cw", ControlWord, 25'd0);
    check("rst_done", done, 1'b0);

    // T1: reset mid-RUN flushes everything
    push(CwA, 64'd1, 2'b01);
    push(CwB, 64'd2, 2'b01);
    push(CwC, 64'd3, 2'b00);
    pulse_go();
    check("t1_first", ControlWord, CwA);
    tick();
    do_reset();
    check("t1_cw", ControlWord, 25'd0);
    check("t1_const", constant, 64'd0);
    check("t1_busy", busy, 1'b0);
    check("t1_ready", push_ready, 1'b1);
    check("t1_count", issue_count, 16'd0);
    pulse_go();
    check("t1_flushed_done", done, 1'b1);
    check("t1_flushed_busy", busy, 1'b0);

    // T2: three NORMAL entries back to back
    do_reset();
    push(CwA, 64'd3, 2'b00);
    push(CwB, 64'd4, 2'b00);
    push(CwC, 64'd5, 2'b00);
    pulse_go();
    check("t2_cw0", ControlWord, CwA); check("t2_k0", constant, 64'd3); check("t2_busy", busy, 1'b1);
    tick();
    check("t2_cw1", ControlWord, CwB); check("t2_k1", constant, 64'd4);
    tick();
    check("t2_cw2", ControlWord, CwC); check("t2_k2", constant, 64'd5);
    check("t2_nodone", done, 1'b0);
    tick();
    check("t2_nop", ControlWord, 25'd0); check("t2_khold", constant, 64'd5);
    check("t2_done", done, 1'b1); check("t2_idle", busy, 1'b0);
    tick();
    check("t2_done_pulse", done, 1'b0);
    check("t2_count", issue_count, 16'd3);

    // T3: HOLD inserts two bubbles
    do_reset();
    push(CwA, 64'd7, 2'b01);
    push(CwB, 64'd8, 2'b00);
    pulse_go();
    check("t3_a", ControlWord, CwA); check("t3_b0", busy, 1'b1);
    tick();
    check("t3_nop1", ControlWord, 25'd0); check("t3_b1", busy, 1'b1); check("t3_k", constant, 64'd7);
    tick();
    check("t3_nop2", ControlWord, 25'd0); check("t3_b2", busy, 1'b1);
    tick();
    check("t3_b", ControlWord, CwB); check("t3_b3", busy, 1'b1); check("t3_kb", constant, 64'd8);
    tick();
    check("t3_end", done, 1'b1);
    check("t3_count", issue_count, 16'd2);

    // T4: DEPTH+1 pushes, last is dropped
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      check($sformatf("t4_ready%0d", i), push_ready, (i < DEPTH) ? 1'b1 : 1'b0);
      push(25'(100 + i), 64'(i), 2'b00);
    end
    check("t4_full", push_ready, 1'b0);
    pulse_go();
    issued  = 0;
    last_cw = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (ControlWord != 25'd0) begin
        issued++;
        last_cw = ControlWord;
      end
      tick();
    end
    check("t4_done", done, 1'b1);
    check("t4_issued", 64'(issued), 64'(DEPTH));
    check("t4_last", last_cw, 25'(100 + DEPTH - 1));
    check("t4_count", issue_count, 16'(DEPTH));
    tick();
    pulse_go();
    check("t4_empty_done", done, 1'b1);
    check("t4_count2", issue_count, 16'(DEPTH));

    // T5: HALT stops, remaining entries stay queued
    do_reset();
    push(CwA, 64'd1, 2'b00);
    push(25'h1FFFFFF, 64'd9, 2'b11);
    push(CwB, 64'd2, 2'b00);
    pulse_go();
    check("t5_a", ControlWord, CwA);
    tick();
    check("t5_halt_cw", ControlWord, 25'd0); check("t5_halt_done", done, 1'b1);
    check("t5_halt_busy", busy, 1'b0);
    tick();
    check("t5_idle", done, 1'b0);
    pulse_go();
    check("t5_b", ControlWord, CwB); check("t5_kb", constant, 64'd2);
    tick();
    check("t5_end", done, 1'b1);
    check("t5_count", issue_count, 16'd2);

    // T6: SKIP keyed on status bit 2
    do_reset();
    push(CwA, 64'd1, 2'b00);
    push(25'h1234, 64'd2, 2'b10);
    push(CwB, 64'd4, 2'b00);
    push(CwC, 64'd5, 2'b00);
    status = 4'b0100;
    pulse_go();
    check("t6_a", ControlWord, CwA);
    tick();
    status = 4'b0000;
    check("t6_skip_nop", ControlWord, 25'd0);
    check("t6_skip_busy", busy, 1'b1);
    tick();
`ifdef SEQ_SKIP_EN
    check("t6_discard", ControlWord, 25'd0);
`else
    check("t6_b", ControlWord, CwB);
`endif
    tick();
    check("t6_c", ControlWord, CwC);
    tick();
    check("t6_done", done, 1'b1);
`ifdef SEQ_SKIP_EN
    check("t6_count", issue_count, 16'd2);
`else
    check("t6_count", issue_count, 16'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
